// File: rtl/common_dffram_wrarb_2req_if.sv
// common_dffram_wrarb_2req_if: requester handshakes, clear control and RAM write port bundle
interface common_dffram_wrarb_2req_if #(
  parameter int RAM_DATA_WIDTH = 1,
  parameter int RAM_ADDR_WIDTH = 1
);
  logic                      req0_valid, req0_ready;
  logic [RAM_ADDR_WIDTH-1:0] req0_addr;
  logic [RAM_DATA_WIDTH-1:0] req0_we, req0_data;
  logic                      req1_valid, req1_ready;
  logic [RAM_ADDR_WIDTH-1:0] req1_addr;
  logic [RAM_DATA_WIDTH-1:0] req1_we, req1_data;
  logic                      clr_req, clr_busy, clr_done;
  logic [RAM_ADDR_WIDTH-1:0] ram_addra;
  logic                      ram_ena;
  logic [RAM_DATA_WIDTH-1:0] ram_wea, ram_dina;
  modport master (
    output req0_valid, req0_addr, req0_we, req0_data,
    output req1_valid, req1_addr, req1_we, req1_data, clr_req,
    input  req0_ready, req1_ready, clr_busy, clr_done, ram_addra, ram_ena, ram_wea, ram_dina
  );
  modport slave (
    input  req0_valid, req0_addr, req0_we, req0_data,
    input  req1_valid, req1_addr, req1_we, req1_data, clr_req,
    output req0_ready, req1_ready, clr_busy, clr_done, ram_addra, ram_ena, ram_wea, ram_dina
  );
endinterface

// File: rtl/common_dffram_wrarb_2req.sv
// common_dffram_wrarb_2req: round-robin two-requester write port arbiter with clear sweep for a DFF RAM
module common_dffram_wrarb_2req #(
  parameter int                        RAM_DATA_WIDTH = 1,
  parameter int                        RAM_ADDR_WIDTH = 1,
  parameter logic [RAM_DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                        CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic reset,
  common_dffram_wrarb_2req_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                    r_state;
  logic                      r_rr, r_pend, r_ena, r_done;
  logic [RAM_ADDR_WIDTH-1:0] r_cnt, r_addr;
  logic [RAM_DATA_WIDTH-1:0] r_we, r_din;
  logic                      w_idle, w_start, w_rdy0, w_rdy1;
  assign w_idle  = r_state == IDLE;
  assign w_start = w_idle & (bus.clr_req | r_pend);
  assign w_rdy0  = w_idle & ~w_start & bus.req0_valid & (~bus.req1_valid | ~r_rr);
  assign w_rdy1  = w_idle & ~w_start & bus.req1_valid & (~bus.req0_valid | r_rr);
  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.clr_busy   = r_state == CLEAR;
  assign bus.clr_done   = r_done;
  assign bus.ram_addra  = r_addr;
  assign bus.ram_ena    = r_ena;
  assign bus.ram_wea    = r_we;
  assign bus.ram_dina   = r_din;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_pend  <= CLEAR_ON_RESET;
      r_addr  <= '0;
      r_ena   <= 1'b0;
      r_we    <= '0;
      r_din   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_ena  <= 1'b0;
      r_done <= 1'b0;
      if (r_state == CLEAR) begin
        r_ena  <= 1'b1;
        r_addr <= r_cnt;
        r_we   <= '1;
        r_din  <= CLEAR_VALUE;
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == '1) begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      end else if (w_start) begin
        r_state <= CLEAR;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
      end else if (w_rdy0 | w_rdy1) begin
        r_ena  <= 1'b1;
        r_addr <= w_rdy0 ? bus.req0_addr : bus.req1_addr;
        r_we   <= w_rdy0 ? bus.req0_we : bus.req1_we;
        r_din  <= w_rdy0 ? bus.req0_data : bus.req1_data;
        r_rr   <= w_rdy0;
      end
    end
  end
endmodule
